// File: rtl/stream_out_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : stream_out_arbiter
//  Description : Packet-granular two-way AXI4-Stream arbiter that shares the
//                host-bound output between the MMIO response path (port 0)
//                and the DMA header/payload engine (port 1). A grant is held
//                from the first beat through the tlast beat, so the two
//                sources never interleave. The data path is combinational
//                (zero latency) and there is no buffering inside the block.
//
//  Ports
//    aclk, areset        : clock, synchronous active-high reset
//    s0_*                : MMIO response stream (tdata/tkeep/tlast/tuser/
//                          tvalid in, tready out)
//    s1_*                : DMA stream (same shape as s0_*)
//    m_*                 : merged output stream (tready in)
//    mmio_grant          : high while the MMIO source owns the output
//    dma_grant           : high while the DMA source owns the output
//    mmio_pkt_count      : wrapping count of s0 tlast beats forwarded
//    dma_pkt_count       : wrapping count of s1 tlast beats forwarded
//
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_out_arbiter #(
    parameter int DATA_BITS  = 64,
    parameter int KEEP_WIDTH = DATA_BITS / 8,
    parameter int PRIO_MODE  = 0,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  aclk,
    input  logic                  areset,

    input  logic [DATA_BITS-1:0]  s0_tdata,
    input  logic [KEEP_WIDTH-1:0] s0_tkeep,
    input  logic                  s0_tlast,
    input  logic                  s0_tuser,
    input  logic                  s0_tvalid,
    output logic                  s0_tready,

    input  logic [DATA_BITS-1:0]  s1_tdata,
    input  logic [KEEP_WIDTH-1:0] s1_tkeep,
    input  logic                  s1_tlast,
    input  logic                  s1_tuser,
    input  logic                  s1_tvalid,
    output logic                  s1_tready,

    output logic [DATA_BITS-1:0]  m_tdata,
    output logic [KEEP_WIDTH-1:0] m_tkeep,
    output logic                  m_tlast,
    output logic                  m_tuser,
    output logic                  m_tvalid,
    input  logic                  m_tready,

    output logic                  mmio_grant,
    output logic                  dma_grant,
    output logic [CNT_WIDTH-1:0]  mmio_pkt_count,
    output logic [CNT_WIDTH-1:0]  dma_pkt_count
);

    // Fixed-priority mode: MMIO wins every arbitration.
    localparam logic                 c_FIXED_PRIO = (PRIO_MODE != 0);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    state_t               r_state;
    // Source that received the most recent grant: 0 = MMIO, 1 = DMA.
    // Resets to 1 so that MMIO wins the first tie in round-robin mode.
    logic                 r_last_grant;
    logic [CNT_WIDTH-1:0] r_mmio_cnt;
    logic [CNT_WIDTH-1:0] r_dma_cnt;

    logic w_sel0;
    logic w_sel1;
    logic w_pkt_done0;
    logic w_pkt_done1;
    logic w_pick0;
    logic w_pick1;

    assign w_sel0 = (r_state == ST_GRANT0);
    assign w_sel1 = (r_state == ST_GRANT1);

    // The end of a packet is the accepted tlast beat of the granted source.
    assign w_pkt_done0 = w_sel0 & s0_tvalid & m_tready & s0_tlast;
    assign w_pkt_done1 = w_sel1 & s1_tvalid & m_tready & s1_tlast;

    // Arbitration decision, only acted on while idle. Requests are tvalid
    // alone; tready is never consulted so there is no valid/ready loop.
    always_comb begin
        w_pick0 = 1'b0;
        w_pick1 = 1'b0;
        if (s0_tvalid && s1_tvalid) begin
            if (c_FIXED_PRIO || r_last_grant) begin
                w_pick0 = 1'b1;
            end else begin
                w_pick1 = 1'b1;
            end
        end else begin
            w_pick0 = s0_tvalid;
            w_pick1 = s1_tvalid;
        end
    end

    // Grant FSM and packet counters. Leaving a grant always passes through
    // IDLE, which costs one bubble cycle per packet boundary but keeps the
    // arbitration decision off the tlast handshake path.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_mmio_cnt   <= '0;
            r_dma_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick0) begin
                        r_state      <= ST_GRANT0;
                        r_last_grant <= 1'b0;
                    end else if (w_pick1) begin
                        r_state      <= ST_GRANT1;
                        r_last_grant <= 1'b1;
                    end
                end
                ST_GRANT0: begin
                    // A mid-packet tvalid drop keeps the grant: the output
                    // stalls with the source rather than interleaving.
                    if (w_pkt_done0) begin
                        r_state    <= ST_IDLE;
                        r_mmio_cnt <= r_mmio_cnt + c_CNT_ONE;
                    end
                end
                ST_GRANT1: begin
                    if (w_pkt_done1) begin
                        r_state   <= ST_IDLE;
                        r_dma_cnt <= r_dma_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Zero-latency data path. Everything is forced to zero when nobody holds
    // the grant, so m_tvalid can never rise without a granted source.
    always_comb begin
        m_tdata   = '0;
        m_tkeep   = '0;
        m_tlast   = 1'b0;
        m_tuser   = 1'b0;
        m_tvalid  = 1'b0;
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        if (w_sel0) begin
            m_tdata   = s0_tdata;
            m_tkeep   = s0_tkeep;
            m_tlast   = s0_tlast;
            m_tuser   = s0_tuser;
            m_tvalid  = s0_tvalid;
            s0_tready = m_tready;
        end else if (w_sel1) begin
            m_tdata   = s1_tdata;
            m_tkeep   = s1_tkeep;
            m_tlast   = s1_tlast;
            m_tuser   = s1_tuser;
            m_tvalid  = s1_tvalid;
            s1_tready = m_tready;
        end
    end

    assign mmio_grant     = w_sel0;
    assign dma_grant      = w_sel1;
    assign mmio_pkt_count = r_mmio_cnt;
    assign dma_pkt_count  = r_dma_cnt;

endmodule
`default_nettype wire
